// File: rtl/multdiv_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide unit.
interface multdiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             hilo_we;
  logic             hilo_sel;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdata;

  modport master (
    output start, op, d1, d2,
    output hilo_we, hilo_sel, cancel,
    input  busy, done, div_zero,
    input  hi, lo, rdata
  );

  modport slave (
    input  start, op, d1, d2,
    input  hilo_we, hilo_sel, cancel,
    output busy, done, div_zero,
    output hi, lo, rdata
  );
endinterface

// File: rtl/multdiv_unit.sv
// HI/LO multiply/divide unit with fixed-latency commit and flush cancel.
// Define MULTDIV_ACC_EN to enable MADD/MADDU/MSUB/MSUBU (ops 4-7).
module multdiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     rst_n,
  multdiv_if.slave mdu
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;

  localparam logic [CW-1:0] MLAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DLAT = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // ---------------- issue decode ----------------
  logic in_div;
  logic in_legal;

  assign in_div = (mdu.op[2:1] == 2'b01);

`ifdef MULTDIV_ACC_EN
  assign in_legal = 1'b1;
`else
  assign in_legal = ~mdu.op[2];
`endif

  // ---------------- datapath ----------------
  logic          sgn;
  logic          is_div;
  logic [W2-1:0] ext_a;
  logic [W2-1:0] ext_b;
  logic [W2-1:0] prod;

  assign sgn    = ~op_q[0];
  assign is_div = (op_q[2:1] == 2'b01);

  assign ext_a = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
  assign ext_b = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             b_zero;

  assign neg_a  = sgn & a_q[WIDTH-1];
  assign neg_b  = sgn & b_q[WIDTH-1];
  assign abs_a  = neg_a ? (~a_q + 1'b1) : a_q;
  assign abs_b  = neg_b ? (~b_q + 1'b1) : b_q;
  assign b_zero = (b_q == '0);

  // Magnitude divide; min/-1 falls out naturally as 2^(W-1).
  assign uq  = b_zero ? '0 : (abs_a / abs_b);
  assign ur  = b_zero ? '0 : (abs_a % abs_b);
  assign quo = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
  assign rem = neg_a ? (~ur + 1'b1) : ur;

`ifdef MULTDIV_ACC_EN
  logic [W2-1:0] acc;
  assign acc = op_q[1] ? ({hi_q, lo_q} - prod)
                       : ({hi_q, lo_q} + prod);
`endif

  logic [W2-1:0] res;
  logic          res_we;

  always_comb begin
    res    = prod;
    res_we = 1'b1;
    unique case (1'b1)
      is_div: begin
        res    = {rem, quo};
        res_we = ~b_zero;
      end
`ifdef MULTDIV_ACC_EN
      op_q[2]: res = acc;
`endif
      default: ;
    endcase
  end

  // ---------------- control ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (!mdu.cancel) begin
          if (mdu.start && in_legal) begin
            op_d    = mdu.op;
            a_d     = mdu.d1;
            b_d     = mdu.d2;
            cnt_d   = in_div ? DLAT : MLAT;
            state_d = RUN;
            busy_d  = 1'b1;
            dz_d    = in_div && (mdu.d2 == '0);
          end else if (mdu.hilo_we && !mdu.start) begin
            if (mdu.hilo_sel) lo_d = mdu.d1;
            else              hi_d = mdu.d1;
          end
        end
      end
      RUN: begin
        if (mdu.cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == ONE) begin
          if (res_we) begin
            hi_d = res[W2-1:WIDTH];
            lo_d = res[WIDTH-1:0];
          end
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign mdu.busy     = busy_q;
  assign mdu.done     = done_q;
  assign mdu.div_zero = dz_q;
  assign mdu.hi       = hi_q;
  assign mdu.lo       = lo_q;
  assign mdu.rdata    = mdu.hilo_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed ops, cancel, reset, MTHI/MTLO.
// Accumulate expectations follow MULTDIV_ACC_EN.
module tb_multdiv_unit;

  logic clk;
  logic rst_n;

  multdiv_if #(.WIDTH(32)) m ();

  multdiv_unit #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mdu  (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n && m.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_hi", 64'(m.hi), 64'(e.hi));
        check("sb_lo", 64'(m.lo), 64'(e.lo));
        check("sb_dz", 64'(m.div_zero), 64'(e.dz));
      end
    end
  end

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic we,
                       input logic cn);
    @(negedge clk);
    m.start   = 1'b1;
    m.op      = o;
    m.d1      = a;
    m.d2      = b;
    m.hilo_we = we;
    m.cancel  = cn;
    @(negedge clk);
    m.start   = 1'b0;
    m.hilo_we = 1'b0;
    m.cancel  = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int n);
    int c;
    c = 0;
    while (m.busy === 1'b1 && c < 50) begin
      c++;
      @(negedge clk);
    end
    check(nm, 64'(c), 64'(n));
  endtask

  task automatic run_op(input string nm,
                        input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input logic edz,
                        input int n);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.dz = edz;
    sb.push_back(e);
    issue(o, a, b, 1'b0, 1'b0);
    wait_idle(nm, n);
  endtask

  task automatic wr(input logic sel, input logic [31:0] v);
    @(negedge clk);
    m.hilo_we  = 1'b1;
    m.hilo_sel = sel;
    m.d1       = v;
    @(negedge clk);
    m.hilo_we  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    m.start    = 1'b0;
    m.op       = 3'd0;
    m.d1       = '0;
    m.d2       = '0;
    m.hilo_we  = 1'b0;
    m.hilo_sel = 1'b0;
    m.cancel   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_busy", 64'(m.busy), 64'd0);
    check("rst_done", 64'(m.done), 64'd0);
    check("rst_dz",   64'(m.div_zero), 64'd0);
    check("rst_hi",   64'(m.hi), 64'd0);
    check("rst_lo",   64'(m.lo), 64'd0);

    run_op("mult_lat", 3'd0, 32'hFFFFFFFD, 32'd7,
           32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 5);
    run_op("divu_lat", 3'd3, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 10);
    run_op("div_lat", 3'd2, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 10);

    wr(1'b0, 32'h11);
    check("mthi_rdata", 64'(m.rdata), 64'h11);
    wr(1'b1, 32'h22);
    check("mtlo_rdata", 64'(m.rdata), 64'h22);

    run_op("div0_lat", 3'd2, 32'd5, 32'd0,
           32'h11, 32'h22, 1'b1, 10);
    check("div0_flag", 64'(m.div_zero), 64'd1);

    run_op("mult_clr", 3'd0, 32'd6, 32'd7,
           32'd0, 32'd42, 1'b0, 5);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF,
           32'd0, 32'h80000000, 1'b0, 10);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, 1'b0, 5);

    // Cancel in the third busy cycle.
    issue(3'd0, 32'd3, 32'd3, 1'b0, 1'b0);
    check("cx_busy1", 64'(m.busy), 64'd1);
    check("cx_hold", 64'(m.lo), 64'h1);
    @(negedge clk);
    @(negedge clk);
    m.cancel = 1'b1;
    @(negedge clk);
    m.cancel = 1'b0;
    check("cx_busy0", 64'(m.busy), 64'd0);
    check("cx_hi", 64'(m.hi), 64'hFFFFFFFE);
    check("cx_lo", 64'(m.lo), 64'h1);
    repeat (6) @(negedge clk);
    check("cx_nodone", 64'(m.done), 64'd0);

    // start beats hilo_we; divide by zero leaves HI/LO visible.
    m.hilo_sel = 1'b1;
    begin
      exp_t e;
      e.hi = 32'hFFFFFFFE;
      e.lo = 32'h1;
      e.dz = 1'b1;
      sb.push_back(e);
    end
    issue(3'd2, 32'd9, 32'd0, 1'b1, 1'b0);
    wait_idle("swe_lat", 10);

    // MTHI blocked by cancel.
    @(negedge clk);
    m.hilo_we  = 1'b1;
    m.hilo_sel = 1'b0;
    m.d1       = 32'h55;
    m.cancel   = 1'b1;
    @(negedge clk);
    m.hilo_we = 1'b0;
    m.cancel  = 1'b0;
    check("cwe_rdata", 64'(m.rdata), 64'hFFFFFFFE);

    // start plus cancel stays idle and keeps div_zero.
    issue(3'd0, 32'd2, 32'd2, 1'b0, 1'b1);
    check("sc_busy", 64'(m.busy), 64'd0);
    check("sc_dz", 64'(m.div_zero), 64'd1);

    wr(1'b0, 32'd0);
    wr(1'b1, 32'd10);
`ifdef MULTDIV_ACC_EN
    run_op("msub_lat", 3'd6, 32'd3, 32'd4,
           32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5);
    run_op("maddu_lat", 3'd5, 32'd2, 32'd1,
           32'd0, 32'd0, 1'b0, 5);
`else
    issue(3'd6, 32'd3, 32'd4, 1'b0, 1'b0);
    check("msub_busy", 64'(m.busy), 64'd0);
    repeat (7) @(negedge clk);
    check("msub_hi", 64'(m.hi), 64'd0);
    check("msub_lo", 64'(m.lo), 64'd10);
`endif

    // Asynchronous reset mid divide.
    issue(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", 64'(m.busy), 64'd0);
    check("ar_hi",   64'(m.hi), 64'd0);
    check("ar_lo",   64'(m.lo), 64'd0);
    check("ar_done", 64'(m.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(1'b1, 32'hABCD);
    check("ar_rdata", 64'(m.rdata), 64'hABCD);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Parametrised multiply/divide/accumulate unit for the EX stage of the pipelined MIPS core, replacing the fixed-width HI/LO unit. It accepts one operation per `start`, holds `busy` for a configurable latency, and commits the result to the internal HI/LO registers. A `cancel` input aborts an in-flight operation on interrupt/exception flush without touching HI/LO. An optional multiply-accumulate mode adds MADD/MADDU/MSUB/MSUBU.

## Interface
- `WIDTH`, 32: operand and HI/LO register width (≥ 8, even).
- `MULT_CYCLES`, 5: busy cycles for multiply and accumulate ops (≥ 1).
- `DIV_CYCLES`, 10: busy cycles for divide ops (≥ 1).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch operation `op` on operands `d1`, `d2`.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `d1`  in  WIDTH  operand A (dividend); also the write data for `hilo_we`.
- `d2`  in  WIDTH  operand B (divisor).
- `hilo_we`  in  1  direct write of `d1` into HI or LO (MTHI/MTLO).
- `hilo_sel`  in  1  0 selects HI, 1 selects LO, for `hilo_we` and for `rdata`.
- `cancel`  in  1  flush: abort the current operation and suppress a same-cycle `start`/`hilo_we`.
- `busy`  out  1  operation in flight; HI/LO results not yet valid.
- `done`  out  1  one-cycle pulse after a commit.
- `div_zero`  out  1  sticky flag: a divide by zero was issued; cleared by the next `start`.
- `hi`, `lo`  out  WIDTH  architectural HI/LO.
- `rdata`  out  WIDTH  `hilo_sel ? lo : hi` (combinational, for MFHI/MFLO).

## Operation
- Two-state FSM: IDLE and RUN. There is a down-counter `cnt`, sized for `max(MULT_CYCLES, DIV_CYCLES)`.
- IDLE with `start`=1 and `cancel`=0:
  - Latch `op`, `d1`, `d2`.
  - Load `cnt` with the op's latency.
  - Move to RUN.
- RUN:
  - `cnt` decrements each cycle.
  - When `cnt` reaches 1, the next edge commits HI/LO, returns to IDLE and raises `done` for one cycle.
- Result computation may be iterative (radix-2 divider) or single-shot held to the counter. Only commit timing is architectural.
- Multiply: signed (MULT) or unsigned (MULTU) 2·WIDTH product; HI gets the upper half, LO the lower half.
- Divide: LO = quotient, HI = remainder. Division truncates toward zero and the remainder takes the dividend's sign (signed ops).
  - Signed overflow (most negative / −1): LO = most negative, HI = 0.
  - Divisor 0: HI/LO unchanged at commit. Latency is still `DIV_CYCLES`, `done` still pulses, and `div_zero` is set.
- MADD/MSUB: {HI,LO} ± product, computed modulo 2^(2·WIDTH). The signed/unsigned choice applies to the product only.
- `hilo_we` in IDLE with `start`=0 and `cancel`=0: the selected register gets `d1` on the edge.
- Ignored inputs:
  - `start` and `hilo_we` while RUN are ignored (the hazard unit stalls on `busy`).
  - `start` and `hilo_we` asserted together: `start` wins and the write is dropped.
- `cancel`:
  - In RUN: go to IDLE on the next edge, HI/LO unchanged, no `done`.
  - In IDLE: blocks `start` and `hilo_we` in the same cycle.
- Reset (asynchronous, any state including mid-RUN): FSM to IDLE, `cnt`=0, `hi`=`lo`=0, `busy`=0, `done`=0, `div_zero`=0.

## Timing
- `busy` is registered. It rises the edge after an accepted `start` and stays high for exactly N cycles (N = `MULT_CYCLES` or `DIV_CYCLES`).
- HI/LO update and `busy` fall happen on the same edge. `done` is high in the following cycle.
- A new `start` is accepted in the first cycle with `busy`=0. Back-to-back ops therefore have N+1 cycles between starts.
- `hilo_we` has 1-cycle latency: `rdata` reflects the write in the next cycle.
- `rdata`, `hi` and `lo` hold their old values throughout RUN.

## Configuration
- `MULTDIV_ACC_EN` defined: ops 4–7 perform accumulate as specified, with `MULT_CYCLES` latency.
- `MULTDIV_ACC_EN` undefined:
  - Ops 4–7 are illegal: `start` with them is ignored (stays IDLE, no `busy`, no `done`).
  - The accumulate adder is not synthesised.

## Test plan
- WIDTH=32, MULT_CYCLES=5: MULT −3 × 7 → `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; `done` pulses once.
- DIVU 100 / 7 → after 10 busy cycles, LO=14, HI=2. Then DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 5 / 0 with HI=0x11, LO=0x22 → after 10 cycles HI/LO unchanged, `done`=1, `div_zero`=1. The next MULT clears `div_zero`.
- `cancel` asserted in RUN cycle 3 of a MULT → `busy` falls next edge, HI/LO keep prior values, no `done`. A `start` plus `cancel` in the same cycle → stays IDLE.
- With `MULTDIV_ACC_EN`, HI=0, LO=10: MSUB 3 × 4 → {HI,LO} = 0xFFFFFFFF_FFFFFFFE. Without the macro the same `start` → no `busy`, HI/LO unchanged.
- `rst_n` low during DIV RUN → `busy`, `hi`, `lo`, `done` go to 0 immediately. Then `hilo_we`=1, `hilo_sel`=1, `d1`=0xABCD → `rdata`=0xABCD the next cycle.
